// File: rtl/xor_share_arbiter.sv
// Round-robin arbiter feeding one shared N-bit XOR through a 2-stage valid/ready pipeline.
// Optional per-requester saturating grant counters are enabled with XOR_ARB_STATS_EN.
module xor_share_arbiter #(
    parameter int N = 16,
    parameter int R = 4,
    localparam int W = $clog2(R)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [R-1:0]   req,
    input  logic [R*N-1:0] a_bus,
    input  logic [R*N-1:0] b_bus,
    output logic [R-1:0]   gnt,
    output logic [N-1:0]   f,
    output logic [W-1:0]   f_id,
    output logic           f_valid,
`ifdef XOR_ARB_STATS_EN
    output logic [R*16-1:0] gnt_cnt,
`endif
    input  logic           f_ready
);

    logic [N-1:0] a_p1;
    logic [N-1:0] b_p1;
    logic [W-1:0] id_p1;
    logic         vld_p1;
    logic [W-1:0] ptr;

    logic         s1_adv;
    logic         s2_adv;
    logic         found;
    logic [W-1:0] win;
    logic         take;
    logic [N-1:0] xor_p1;

    assign s2_adv = !f_valid || f_ready;
    assign s1_adv = !vld_p1 || s2_adv;

    // Priority search begins just after the last winner, so a requester
    // that keeps asking only repeats when nobody else is asking.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= R; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= R) idx = idx - R;
            if (!found && req[idx[W-1:0]]) begin
                found = 1'b1;
                win   = idx[W-1:0];
            end
        end
    end

    assign take = found && s1_adv;

    // Grant is forced low while reset is held so no requester believes it was served.
    always_comb begin
        gnt = '0;
        if (rst_n && take) gnt = R'(1) << win;
    end

    // ---- stage 1: operand capture ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_p1   <= '0;
            b_p1   <= '0;
            id_p1  <= '0;
            vld_p1 <= 1'b0;
            ptr    <= W'(R - 1);
        end else if (s1_adv) begin
            if (found) begin
                a_p1   <= a_bus[int'(win)*N +: N];
                b_p1   <= b_bus[int'(win)*N +: N];
                id_p1  <= win;
                vld_p1 <= 1'b1;
                ptr    <= win;
            end else begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign xor_p1 = a_p1 ^ b_p1;

    // ---- stage 2: result register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f       <= '0;
            f_id    <= '0;
            f_valid <= 1'b0;
        end else if (s2_adv) begin
            f       <= xor_p1;
            f_id    <= id_p1;
            f_valid <= vld_p1;
        end
    end

`ifdef XOR_ARB_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] cnt [R];

    for (genvar i = 0; i < R; i++) begin : g_cnt
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt[i] <= '0;
            end else if (gnt[i]) begin
                cnt[i] <= sat_inc(cnt[i]);
            end
        end
        assign gnt_cnt[i*16 +: 16] = cnt[i];
    end
`endif

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Scoreboard bench for xor_share_arbiter: a rotating-priority reference model predicts
// grants and results; a separate monitor checks every presented result in order.
module tb_xor_share_arbiter;
    localparam int N = 16;
    localparam int R = 4;
    localparam int W = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [R-1:0]   req;
    logic [R*N-1:0] a_bus;
    logic [R*N-1:0] b_bus;
    logic [R-1:0]   gnt;
    logic [N-1:0]   f;
    logic [W-1:0]   f_id;
    logic           f_valid;
    logic           f_ready;
`ifdef XOR_ARB_STATS_EN
    logic [R*16-1:0] gnt_cnt;
`endif

    xor_share_arbiter #(.N(N), .R(R)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .a_bus   (a_bus),
        .b_bus   (b_bus),
        .gnt     (gnt),
        .f       (f),
        .f_id    (f_id),
        .f_valid (f_valid),
`ifdef XOR_ARB_STATS_EN
        .gnt_cnt (gnt_cnt),
`endif
        .f_ready (f_ready)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [N-1:0] res;
        int           id;
        int           gcyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   last_stall = -1;

    // reference model state: rotating pointer and occupancy of the two stages
    int   m_ptr = R - 1;
    bit   m_s1 = 0;
    bit   m_s2 = 0;
    int   m_win = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_ptr = R - 1;
        m_s1  = 0;
        m_s2  = 0;
        m_win = -1;
    endtask

    // Drive one cycle of inputs (called just after a rising edge), check gnt
    // against the model mid-cycle, advance the model, return the DUT grant.
    task automatic step(input logic [R-1:0] r, input logic [R*N-1:0] a, input logic [R*N-1:0] b,
                        input logic rdy, output logic [R-1:0] g_seen);
        bit s2adv, s1adv, fnd;
        int w;
        logic [R-1:0] expg;
        exp_t e;
        req = r; a_bus = a; b_bus = b; f_ready = rdy;
        @(negedge clk);
        s2adv = !m_s2 || rdy;
        s1adv = !m_s1 || s2adv;
        fnd = 0; w = 0;
        for (int k = 1; k <= R; k++) begin
            int idx;
            idx = (m_ptr + k) % R;
            if (!fnd && r[idx]) begin fnd = 1; w = idx; end
        end
        expg = (s1adv && fnd) ? (R'(1) << w) : '0;
        g_seen = gnt;
        chk("gnt", 32'(gnt), 32'(expg));
        if (!rdy) last_stall = cycle;
        if (s2adv) m_s2 = m_s1;
        if (s1adv) m_s1 = (expg != 0);
        m_win = -1;
        if (expg != 0) begin
            m_ptr = w;
            m_win = w;
            e.res  = a[w*N +: N] ^ b[w*N +: N];
            e.id   = w;
            e.gcyc = cycle;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented result must be the oldest outstanding grant.
    always @(negedge clk) begin
        if (rst_n) begin
            if (f_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_f_valid", 32'(f_valid), 32'd0);
                end else begin
                    chk("f", 32'(f), 32'(sb[0].res));
                    chk("f_id", 32'(f_id), 32'(sb[0].id));
                    chk("latency_early", 32'(cycle >= sb[0].gcyc + 2), 32'd1);
                    if (f_ready) void'(sb.pop_front());
                end
            end else if (sb.size() > 0 && sb[0].gcyc > last_stall && cycle >= sb[0].gcyc + 2) begin
                chk("latency_late", 32'(f_valid), 32'd1);
            end
        end
    end

    logic [R-1:0]   g;
    logic [R*N-1:0] ra, rb;
    logic [R-1:0]   rr;
    int             ngr;

    task automatic do_reset();
        req = '1;
        rst_n = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_f_valid", 32'(f_valid), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; a_bus = '0; b_bus = '0; f_ready = 1'b1;
        #2 req = '1;
        #1;
        chk("por_gnt", 32'(gnt), 32'd0);
        chk("por_f", 32'(f), 32'd0);
        chk("por_f_id", 32'(f_id), 32'd0);
        chk("por_f_valid", 32'(f_valid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // single operation from requester 2
        ra = '0; rb = '0;
        ra[2*N +: N] = 16'hAAAA;
        rb[2*N +: N] = 16'h00FF;
        step(4'b0100, ra, rb, 1'b1, g);
        chk("single_gnt", 32'(g), 32'h4);
        for (int i = 0; i < 4; i++) step(4'b0000, ra, rb, 1'b1, g);

        // fill both stages under back-pressure, then reset mid-stream
        for (int i = 0; i < 3; i++) step(4'b1111, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b0, g);
        do_reset();

        // round-robin with distinct operands
        ra = {16'h1234, 16'hF00D, 16'h0F0F, 16'hFFFF};
        rb = {16'h00FF, 16'hBEEF, 16'h3333, 16'h5555};
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, ra, rb, 1'b1, g);
            chk("rr_gnt", 32'(g), 32'(1 << (k % R)));
        end
        for (int i = 0; i < 4; i++) step(4'b0000, ra, rb, 1'b1, g);

        // back-pressure: only two grants can fit while the output is stalled
        ngr = 0;
        for (int i = 0; i < 5; i++) begin
            step(4'b0011, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b0, g);
            if (g != 0) ngr++;
        end
        chk("bp_grants", 32'(ngr), 32'd2);
        for (int i = 0; i < 5; i++) step(4'b0000, ra, rb, 1'b1, g);

        // idle gaps with requester 3
        for (int i = 0; i < 8; i++)
            step((i % 2) ? 4'b1000 : 4'b0000, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b1, g);

        // randomized traffic; requesters hold req and operands until granted
        rr = '0; ra = '0; rb = '0;
        for (int i = 0; i < 2000; i++) begin
            for (int j = 0; j < R; j++) begin
                if (!rr[j]) begin
                    rr[j] = ($urandom_range(0, 1) == 1);
                    ra[j*N +: N] = N'($urandom());
                    rb[j*N +: N] = N'($urandom());
                end
            end
            step(rr, ra, rb, ($urandom_range(0, 9) < 7), g);
            if (m_win >= 0) rr[m_win] = 1'b0;
        end

        for (int i = 0; i < 20 && sb.size() > 0; i++) step(4'b0000, ra, rb, 1'b1, g);
        chk("drain_empty", 32'(sb.size()), 32'd0);

`ifdef XOR_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 70000; i++) step(4'b0001, ra, rb, 1'b1, g);
        chk("cnt0_sat", 32'(gnt_cnt[15:0]), 32'hFFFF);
        for (int j = 1; j < R; j++) chk("cnt_other", 32'(gnt_cnt[j*16 +: 16]), 32'd0);
        for (int i = 0; i < 20 && sb.size() > 0; i++) step(4'b0000, ra, rb, 1'b1, g);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/xor_share_arbiter.md
# xor_share_arbiter

Round-robin arbiter and 2-stage pipeline that shares one N-bit bitwise XOR unit among R requesters. Each requester presents an operand pair with a request. The arbiter grants one requester per cycle, registers its operands and drives them through the shared XOR datapath. The result comes out with a valid/ready handshake and the winning requester's ID. The block sits between the requesting engines and the single XOR instance, so the team avoids instantiating one XOR per engine.

## Interface

- N, 16, operand/result width in bits
- R, 4, number of requesters (2..8); ID width W = clog2(R)
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  R  request per requester, level-sensitive
- a_bus  input  R*N  operand A; requester i at bits [i*N +: N]
- b_bus  input  R*N  operand B; same packing as a_bus
- gnt  output  R  one-hot grant, combinational, operands sampled at end of cycle
- f  output  N  registered result A^B
- f_id  output  W  requester index that produced f
- f_valid  output  1  f/f_id valid
- f_ready  input  1  downstream accepts f this cycle
- gnt_cnt  output  R*16  per-requester grant counters (only with XOR_ARB_STATS_EN)

## Operation

- Stage 1 (s1): registers a_q, b_q, id_q, s1_v. Stage 2 (s2): registers f, f_id, f_valid.
- The shared XOR unit computes a_q ^ b_q from the stage 1 registers.
- s2_adv = !f_valid | f_ready; s1_adv = !s1_v | s2_adv.
- Arbitration: the search starts at ptr+1 mod R and the first asserted req wins. gnt[win] = s1_adv & req[win]. gnt is all-zero when there is no request or when s1_adv=0.
- On a grant: a_q/b_q ← requester's operands, id_q ← win, s1_v ← 1, ptr ← win.
- If s1_adv and no grant, s1_v ← 0.
- If s2_adv: f ← a_q^b_q, f_id ← id_q, f_valid ← s1_v.
- A requester holding req high gets back-to-back grants only if no other requester is asserted; otherwise grants rotate.
- Requesters must hold req and operands stable until they see gnt. They may drop req in the cycle after gnt.
- Stall: while f_valid & !f_ready, f/f_id hold and stage 1 holds if it is full. No data is lost or duplicated.

## Timing

- Reset (async assert, sync release): gnt=0, f=0, f_id=0, f_valid=0, s1_v=0, a_q=b_q=0, ptr=R-1 (requester 0 has first priority), gnt_cnt=0.
- Latency: gnt high in cycle c gives f_valid high in cycle c+2 if not stalled.
- Throughput: one result per cycle while f_ready=1.
- Reset mid-operation: in-flight operations in s1 and s2 are discarded and no f_valid is produced for them. The arbiter restarts at requester 0.
- Simultaneous stall release and new request: when f_ready=1 with both stages full, both stages advance and a new grant is issued in the same cycle.
- Pointer wrap: after ptr=R-1, the search starts at 0.
- A req pulse that drops before being granted is lost, with no error.

## Configuration

- XOR_ARB_STATS_EN defined:
  - Adds port gnt_cnt and R 16-bit counters.
  - Counter i increments on every cycle with gnt[i]=1 and saturates at 16'hFFFF.
  - Counters are cleared only by reset.
- XOR_ARB_STATS_EN undefined: the gnt_cnt port and counters are absent. All other behaviour is identical.

## Test plan

- Reset check: assert rst_n=0 mid-stream with both stages full → f_valid=0, gnt=0 immediately. After release, req=4'b1111 → first gnt=4'b0001.
- Single op, requester 2: a=16'hAAAA, b=16'h00FF, f_ready=1 → gnt=4'b0100 in cycle c; f=16'hAA55, f_id=2, f_valid=1 in c+2 for exactly one cycle.
- Round-robin: req=4'b1111 held, operands per requester distinct (e.g. req 1: 16'h0F0F^16'h3333=16'h3C3C) → grants 0,1,2,3,0 on consecutive cycles. f_id sequence matches, each with the correct f.
- Back-pressure: f_ready=0 for 5 cycles while req=4'b0011 → at most 2 grants issued, f/f_id stable. After f_ready=1, all results appear in grant order with none dropped or duplicated.
- Idle gaps: alternating req=0 / req=4'b1000 → f_valid pulses two cycles after each grant, f_id=3, and f_valid=0 in between.
- With XOR_ARB_STATS_EN: 70000 consecutive grants to requester 0 → gnt_cnt[15:0]=16'hFFFF (saturated), other counters 0.
